regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
- Sequences the 32x32 register file write port (A3/WD3/WE3) between two writeback requesters: port 0 (single-cycle ALU path) and port 1 (long-latency load/mul-div path).
- Keeps a 32-entry busy scoreboard of destinations allocated at issue and stalls issue on RAW/WAW hazards.
- Sits between issue/writeback logic and the register file; its outputs drive the register file's write port directly.

Parameters:
XLEN, 32, data width of WD3 and requester data
AW, 5, register address width (2**AW registers; x0 hardwired zero)

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  reset, asynchronous, active-low
ISS_VALID  input  1  issue stage presents an instruction
ISS_RD  input  AW  destination to allocate
ISS_SRC1  input  AW  source 1 to hazard-check
ISS_SRC2  input  AW  source 2 to hazard-check
ISS_STALL  output  1  issue must hold (hazard)
REQ0_VALID  input  1  port 0 writeback request
REQ0_RD  input  AW  port 0 destination
REQ0_DATA  input  XLEN  port 0 data
REQ0_READY  output  1  port 0 granted
REQ1_VALID  input  1  port 1 writeback request
REQ1_RD  input  AW  port 1 destination
REQ1_DATA  input  XLEN  port 1 data
REQ1_READY  output  1  port 1 granted
A3  output  AW  register file write address (registered)
WD3  output  XLEN  register file write data (registered)
WE3  output  1  register file write enable (registered, 1-cycle pulse)
BUSY  output  2**AW  scoreboard (bit 0 always 0)
WB_ERR  output  1  sticky: writeback to non-busy nonzero register

Behaviour:
- Reset (RST_N low, asynchronous, effective immediately, including mid-transfer): BUSY=0, A3=0, WD3=0, WE3=0, WB_ERR=0, arbitration pointer to port 0. In-flight grants are discarded; requesters re-present after reset.
- Handshake: transfer on VALID && READY at rising CLK edge. READY is combinational from VALID and the arbitration state. At most one READY high per cycle. READY is never high without its VALID. A requester holds VALID, RD and DATA stable until transfer.
- Arbitration (default): fixed priority, port 0 wins when both are valid.
- Write-port latency is 1 cycle: after a transfer, A3/WD3 take the granted RD/DATA and WE3=1 for exactly one cycle. In a cycle with no transfer, WE3=0 and A3/WD3 hold their last values. Back-to-back transfers give WE3 high on consecutive cycles.
- RD=0 writeback: the transfer is accepted (READY follows normal arbitration) but WE3 stays 0, A3/WD3 hold, BUSY is unchanged and WB_ERR is not set.
- Scoreboard set: ISS_VALID && !ISS_STALL && ISS_RD!=0 sets BUSY[ISS_RD] at the clock edge.
- Scoreboard clear: a transfer with RD!=0 clears BUSY[RD] at the clock edge. If BUSY[RD] was already 0, WB_ERR is set and stays set until reset.
- ISS_STALL = ISS_VALID && (BUSY[ISS_SRC1] || BUSY[ISS_SRC2] || BUSY[ISS_RD]), using registered BUSY only. There is no same-cycle bypass of a clearing writeback; issue proceeds the cycle after BUSY drops. Index 0 never stalls.
- Simultaneous set and clear on the same index cannot occur, because a busy destination stalls issue. An implementation applies clear before set regardless.
- Set of index i and clear of index j!=i in the same cycle both take effect.

Optional Feature:
ARB_RR_EN
- Defined: round-robin arbitration. A 1-bit last-grant pointer flips to the granted port after each transfer, and the other port wins the next contention. The pointer resets to favour port 0. A lone valid requester is always granted.
- Undefined: fixed priority to port 0; the pointer logic is absent.

Test Plan:
- Reset: drive RST_N low mid-cycle while REQ0 transfers to x5 -> WE3=0, A3=0, WD3=0, BUSY=0, WB_ERR=0 immediately, with no write after release.
- Single write: issue ISS_RD=7, then REQ0 RD=7 DATA=0xDEADBEEF -> BUSY[7]=1 after issue; the cycle after transfer A3=7, WD3=0xDEADBEEF, WE3=1 for one cycle; BUSY[7]=0.
- Hazard: BUSY[3]=1, issue ISS_SRC1=3 -> ISS_STALL=1 until REQ1 RD=3 transfers; ISS_STALL=0 the following cycle. ISS_SRC1=0 never stalls.
- Contention: both valid for 4 cycles, RD 1 and 2, distinct data each cycle. Default -> port 0 granted all 4 cycles, REQ1_READY=0. With ARB_RR_EN -> grants alternate 0,1,0,1.
- x0 write: REQ1 RD=0 DATA=0x1234 -> REQ1_READY=1, WE3 stays 0, BUSY and WB_ERR unchanged.
- Error: REQ0 RD=9 with BUSY[9]=0 -> write occurs (WE3=1, A3=9), WB_ERR=1 and stays set until RST_N low.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// regfile_wb_scheduler: two-port writeback arbiter and busy scoreboard that
// drives the register file write port. Define ARB_RR_EN for round-robin.
// Revision: 1.0
// ============================================================================
module regfile_wb_scheduler #(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              iss_valid,
   input  logic [AW-1:0]     iss_rd,
   input  logic [AW-1:0]     iss_src1,
   input  logic [AW-1:0]     iss_src2,
   output logic              iss_stall,
   input  logic              req0_valid,
   input  logic [AW-1:0]     req0_rd,
   input  logic [XLEN-1:0]   req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [AW-1:0]     req1_rd,
   input  logic [XLEN-1:0]   req1_data,
   output logic              req1_ready,
   output logic [AW-1:0]     a3,
   output logic [XLEN-1:0]   wd3,
   output logic              we3,
   output logic [2**AW-1:0]  busy,
   output logic              wb_err
);

   localparam int NREG = 2**AW;

   logic [NREG-1:0] busy_r;
   logic [NREG-1:0] busy_nxt;
   logic            grant0;
   logic            grant1;
   logic            xfer;
   logic [AW-1:0]   xfer_rd;
   logic [XLEN-1:0] xfer_data;
   logic            xfer_wr;
   logic            iss_go;

`ifdef ARB_RR_EN
   // last_grant = 1 means port 1 was granted last, so port 0 wins contention
   logic last_grant;

   always_comb begin
      grant0 = req0_valid && (!req1_valid || last_grant);
      grant1 = req1_valid && (!req0_valid || !last_grant);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
      end else if (grant0 || grant1) begin
         last_grant <= grant1;
      end
   end
`else
   always_comb begin
      grant0 = req0_valid;
      grant1 = req1_valid && !req0_valid;
   end
`endif

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign xfer       = grant0 || grant1;
   assign xfer_rd    = grant0 ? req0_rd   : req1_rd;
   assign xfer_data  = grant0 ? req0_data : req1_data;
   assign xfer_wr    = xfer && (xfer_rd != '0);

   // Hazard check sees only registered state; a clearing writeback helps next cycle
   assign iss_stall = iss_valid &&
                      (busy_r[iss_src1] || busy_r[iss_src2] || busy_r[iss_rd]);
   assign iss_go    = iss_valid && !iss_stall && (iss_rd != '0);

   always_comb begin
      busy_nxt = busy_r;
      if (xfer_wr) begin
         busy_nxt[xfer_rd] = 1'b0;
      end
      if (iss_go) begin
         busy_nxt[iss_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= '0;
         wb_err <= 1'b0;
         a3     <= '0;
         wd3    <= '0;
         we3    <= 1'b0;
      end else begin
         busy_r <= busy_nxt;
         we3    <= xfer_wr;
         if (xfer_wr) begin
            a3  <= xfer_rd;
            wd3 <= xfer_data;
            if (!busy_r[xfer_rd]) begin
               wb_err <= 1'b1;
            end
         end
      end
   end

   assign busy = busy_r;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// tb_regfile_wb_scheduler: directed self-checking bench for regfile_wb_scheduler.
// Revision: 1.0
// ============================================================================
module tb_regfile_wb_scheduler;

   localparam int XLEN = 32;
   localparam int AW   = 5;

   logic            clk;
   logic            rst_n;
   logic            iss_valid;
   logic [AW-1:0]   iss_rd;
   logic [AW-1:0]   iss_src1;
   logic [AW-1:0]   iss_src2;
   logic            iss_stall;
   logic            req0_valid;
   logic [AW-1:0]   req0_rd;
   logic [XLEN-1:0] req0_data;
   logic            req0_ready;
   logic            req1_valid;
   logic [AW-1:0]   req1_rd;
   logic [XLEN-1:0] req1_data;
   logic            req1_ready;
   logic [AW-1:0]   a3;
   logic [XLEN-1:0] wd3;
   logic            we3;
   logic [31:0]     busy;
   logic            wb_err;

   int checks = 0;
   int errors = 0;

   regfile_wb_scheduler #(.XLEN(XLEN), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_src1(iss_src1),
      .iss_src2(iss_src2), .iss_stall(iss_stall),
      .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data),
      .req1_ready(req1_ready),
      .a3(a3), .wd3(wd3), .we3(we3), .busy(busy), .wb_err(wb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      #1;
      checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL rst_we3 got %b want 0", we3); end
      checks++; if (a3 !== 5'd0) begin errors++; $display("FAIL rst_a3 got %0d want 0", a3); end
      checks++; if (wd3 !== 32'd0) begin errors++; $display("FAIL rst_wd3 got %h want 0", wd3); end
      checks++; if (busy !== 32'd0) begin errors++; $display("FAIL rst_busy got %h want 0", busy); end
      checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", wb_err); end
      @(negedge clk);
      rst_n = 1'b1;
      iss_valid = 1'b1; iss_rd = 5'd5; iss_src1 = 5'd0; iss_src2 = 5'd0;
      @(negedge clk);
      iss_valid = 1'b0;
      req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'h0000_0055;
      @(posedge clk);
      #1;
      checks++; if (we3 !== 1'b1) begin errors++; $display("FAIL pre_rst_we3 got %b want 1", we3); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL midrst_we3 got %b want 0", we3); end
      checks++; if (a3 !== 5'd0) begin errors++; $display("FAIL midrst_a3 got %0d want 0", a3); end
      checks++; if (wd3 !== 32'd0) begin errors++; $display("FAIL midrst_wd3 got %h want 0", wd3); end
      checks++; if (busy !== 32'd0) begin errors++; $display("FAIL midrst_busy got %h want 0", busy); end
      checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL midrst_err got %b want 0", wb_err); end
      req0_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL postrst_we3 got %b want 0", we3); end
      checks++; if (a3 !== 5'd0) begin errors++; $display("FAIL postrst_a3 got %0d want 0", a3); end
   endtask

   task automatic test_single_write();
      @(negedge clk);
      iss_valid = 1'b1; iss_rd = 5'd7; iss_src1 = 5'd0; iss_src2 = 5'd0;
      #1;
      checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL sw_stall got %b want 0", iss_stall); end
      @(negedge clk);
      iss_valid = 1'b0;
      checks++; if (busy !== 32'h0000_0080) begin errors++; $display("FAIL sw_busy_set got %h want 00000080", busy); end
      req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'hDEAD_BEEF;
      #1;
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL sw_ready0 got %b want 1", req0_ready); end
      checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL sw_ready1 got %b want 0", req1_ready); end
      @(posedge clk);
      #1;
      checks++; if (we3 !== 1'b1) begin errors++; $display("FAIL sw_we3 got %b want 1", we3); end
      checks++; if (a3 !== 5'd7) begin errors++; $display("FAIL sw_a3 got %0d want 7", a3); end
      checks++; if (wd3 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wd3 got %h want deadbeef", wd3); end
      checks++; if (busy !== 32'd0) begin errors++; $display("FAIL sw_busy_clr got %h want 0", busy); end
      @(negedge clk);
      req0_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL sw_we3_pulse got %b want 0", we3); end
      checks++; if (a3 !== 5'd7) begin errors++; $display("FAIL sw_a3_hold got %0d want 7", a3); end
      checks++; if (wd3 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wd3_hold got %h want deadbeef", wd3); end
   endtask

   task automatic test_hazard();
      @(negedge clk);
      iss_valid = 1'b1; iss_rd = 5'd3; iss_src1 = 5'd0; iss_src2 = 5'd0;
      @(negedge clk);
      iss_rd = 5'd10; iss_src1 = 5'd3; iss_src2 = 5'd0;
      #1;
      checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL hz_stall got %b want 1", iss_stall); end
      iss_src1 = 5'd0;
      #1;
      checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL hz_src0 got %b want 0", iss_stall); end
      iss_src1 = 5'd3;
      req1_valid = 1'b1; req1_rd = 5'd3; req1_data = 32'h0000_0033;
      #1;
      checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL hz_nobypass got %b want 1", iss_stall); end
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL hz_ready1 got %b want 1", req1_ready); end
      checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL hz_ready0 got %b want 0", req0_ready); end
      @(negedge clk);
      req1_valid = 1'b0;
      #1;
      checks++; if (busy !== 32'd0) begin errors++; $display("FAIL hz_busy got %h want 0", busy); end
      checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL hz_release got %b want 0", iss_stall); end
      iss_valid = 1'b0;
   endtask

   task automatic test_x0_write();
      @(negedge clk);
      req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'h0000_1234;
      #1;
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL x0_ready1 got %b want 1", req1_ready); end
      @(posedge clk);
      #1;
      checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL x0_we3 got %b want 0", we3); end
      checks++; if (a3 !== 5'd3) begin errors++; $display("FAIL x0_a3 got %0d want 3", a3); end
      checks++; if (wd3 !== 32'h0000_0033) begin errors++; $display("FAIL x0_wd3 got %h want 00000033", wd3); end
      checks++; if (busy !== 32'd0) begin errors++; $display("FAIL x0_busy got %h want 0", busy); end
      checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL x0_err got %b want 0", wb_err); end
      @(negedge clk);
      req1_valid = 1'b0;
   endtask

   task automatic test_error();
      @(negedge clk);
      req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'h0000_0099;
      @(posedge clk);
      #1;
      checks++; if (we3 !== 1'b1) begin errors++; $display("FAIL err_we3 got %b want 1", we3); end
      checks++; if (a3 !== 5'd9) begin errors++; $display("FAIL err_a3 got %0d want 9", a3); end
      checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", wb_err); end
      @(negedge clk);
      req0_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", wb_err); end
   endtask

   task automatic test_contention();
      logic [XLEN-1:0] d0;
      logic [XLEN-1:0] d1;
      int              g;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL cont_err_clr got %b want 0", wb_err); end
      @(negedge clk);
      rst_n = 1'b1;
      d0 = 32'h0000_00A0;
      d1 = 32'h0000_00B0;
      for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
         g = i % 2;
`else
         g = 0;
`endif
         req0_valid = 1'b1; req0_rd = 5'd1; req0_data = d0;
         req1_valid = 1'b1; req1_rd = 5'd2; req1_data = d1;
         #1;
         checks++; if (req0_ready !== (g == 0)) begin errors++; $display("FAIL cont_ready0[%0d] got %b want %b", i, req0_ready, g == 0); end
         checks++; if (req1_ready !== (g == 1)) begin errors++; $display("FAIL cont_ready1[%0d] got %b want %b", i, req1_ready, g == 1); end
         @(posedge clk);
         #1;
         checks++; if (we3 !== 1'b1) begin errors++; $display("FAIL cont_we3[%0d] got %b want 1", i, we3); end
         checks++; if (a3 !== ((g == 0) ? 5'd1 : 5'd2)) begin errors++; $display("FAIL cont_a3[%0d] got %0d want %0d", i, a3, (g == 0) ? 1 : 2); end
         checks++; if (wd3 !== ((g == 0) ? d0 : d1)) begin errors++; $display("FAIL cont_wd3[%0d] got %h want %h", i, wd3, (g == 0) ? d0 : d1); end
         @(negedge clk);
         if (g == 0) d0 = d0 + 32'd1;
         else        d1 = d1 + 32'd1;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      iss_valid = 1'b0; iss_rd = '0; iss_src1 = '0; iss_src2 = '0;
      req0_valid = 1'b0; req0_rd = '0; req0_data = '0;
      req1_valid = 1'b0; req1_rd = '0; req1_data = '0;
      test_reset();
      test_single_write();
      test_hazard();
      test_x0_write();
      test_error();
      test_contention();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
